// File: rtl/bcd_subtractor_serial.sv
// Digit-serial packed-BCD subtractor: diff = a - b - bin, one digit per clock, LSD first.
// Out-of-range input digits short-circuit to FIN with invalid=1 and a zero result.
module bcd_subtractor_serial #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   diff,
    output logic                  borrow_out,
    output logic                  invalid
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   diff_q, diff_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           brw_q, brw_d;
    logic           borrow_q, borrow_d;
    logic           invalid_q, invalid_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [3:0]     a_dig_c, b_dig_c, res_dig_c;
    logic [4:0]     t_c;
    logic           in_bad_c;

    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // Current digit pair selected by the digit index.
    always_comb begin
        a_dig_c = 4'd0;
        b_dig_c = 4'd0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                a_dig_c = a_q[4*i +: 4];
                b_dig_c = b_q[4*i +: 4];
            end
        end
        // 5-bit signed difference; bit 4 set means the digit went negative.
        t_c       = 5'({1'b0, a_dig_c}) - 5'({1'b0, b_dig_c}) - 5'(brw_q);
        res_dig_c = t_c[4] ? 4'(t_c[3:0] + 4'd10) : t_c[3:0];
        in_bad_c  = has_bad_digit(a) | has_bad_digit(b);
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        diff_d    = diff_q;
        idx_d     = idx_q;
        brw_d     = brw_q;
        borrow_d  = borrow_q;
        invalid_d = invalid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        // busy drops the cycle after the done pulse.
        if (done_q) busy_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !busy_q) begin
                    a_d       = a;
                    b_d       = b;
                    diff_d    = '0;
                    borrow_d  = 1'b0;
                    idx_d     = '0;
                    busy_d    = 1'b1;
                    if (in_bad_c) begin
                        invalid_d = 1'b1;
                        brw_d     = 1'b0;
                        state_d   = S_FIN;
                    end else begin
                        invalid_d = 1'b0;
                        brw_d     = bin;
                        state_d   = S_RUN;
                    end
                end
            end
            S_RUN: begin
                for (int unsigned i = 0; i < DIGITS; i++) begin
                    if (idx_q == IW'(i)) diff_d[4*i +: 4] = res_dig_c;
                end
                brw_d = t_c[4];
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) state_d = S_FIN;
            end
            S_FIN: begin
                borrow_d = brw_q;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            diff_q    <= '0;
            idx_q     <= '0;
            brw_q     <= 1'b0;
            borrow_q  <= 1'b0;
            invalid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            diff_q    <= diff_d;
            idx_q     <= idx_d;
            brw_q     <= brw_d;
            borrow_q  <= borrow_d;
            invalid_q <= invalid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
    assign invalid    = invalid_q;

endmodule

// File: tb/tb_bcd_subtractor_serial.sv
// Self-checking bench for bcd_subtractor_serial: directed and random operands
// compared against a decimal-arithmetic reference model.
module tb_bcd_subtractor_serial;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned W      = 4 * DIGITS;
    localparam int unsigned MAXW   = 3 * DIGITS + 10;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         invalid;

    int unsigned n_pass;
    int unsigned n_total;

    bcd_subtractor_serial #(.DIGITS(DIGITS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .bin        (bin),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .invalid    (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic longint bcd_val(input logic [W-1:0] v);
        longint r;
        longint m;
        r = 0;
        m = 1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            r = r + longint'(v[4*i +: 4]) * m;
            m = m * 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] to_bcd(input longint x);
        logic [W-1:0] v;
        longint       t;
        t = x;
        v = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            v[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return v;
    endfunction

    function automatic logic any_bad(input logic [W-1:0] v);
        logic r;
        r = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) if (v[4*i +: 4] > 4'd9) r = 1'b1;
        return r;
    endfunction

    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                         output logic [W-1:0] ed, output logic eb, output logic ei,
                         output int elat);
        longint r;
        longint modv;
        modv = 1;
        for (int i = 0; i < int'(DIGITS); i++) modv = modv * 10;
        if (any_bad(ma) || any_bad(mb)) begin
            ed = '0; eb = 1'b0; ei = 1'b1; elat = 1;
        end else begin
            r  = bcd_val(ma) - bcd_val(mb) - longint'(mbin);
            eb = (r < 0);
            if (r < 0) r = r + modv;
            ed = to_bcd(r); ei = 1'b0; elat = int'(DIGITS) + 1;
        end
    endtask

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] v;
        for (int i = 0; i < int'(DIGITS); i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    // ---------------- stimulus helpers ----------------
    // Presents operands, lets the start edge pass, then scrambles the inputs.
    task automatic start_op(input logic [W-1:0] sa, input logic [W-1:0] sb, input logic sbin);
        @(negedge clk);
        a = sa; b = sb; bin = sbin; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    endtask

    task automatic wait_done(output int edges, output logic seen);
        edges = 0;
        seen  = 1'b0;
        for (int k = 0; k < int'(MAXW); k++) begin
            @(posedge clk);
            edges++;
            #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({busy, done, diff, borrow_out, invalid} !== '0)
            $display("FAIL reset_outputs: got busy=%b done=%b diff=%h brw=%b inv=%b expected all 0",
                     busy, done, diff, borrow_out, invalid);
        else n_pass++;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_total++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_idle: got busy=%b done=%b expected 0 0", busy, done);
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [W-1:0] ta[6];
        logic [W-1:0] tb_[6];
        logic         tbin[6];
        logic [W-1:0] ed;
        logic         eb, ei, seen;
        int           elat, lat;
        ta[0] = 16'h0042; tb_[0] = 16'h0017; tbin[0] = 1'b0;
        ta[1] = 16'h0017; tb_[1] = 16'h0042; tbin[1] = 1'b0;
        ta[2] = 16'h0000; tb_[2] = 16'h0000; tbin[2] = 1'b1;
        ta[3] = 16'h1000; tb_[3] = 16'h0001; tbin[3] = 1'b0;
        ta[4] = 16'h00A0; tb_[4] = 16'h0001; tbin[4] = 1'b0;
        ta[5] = 16'h9999; tb_[5] = 16'h9999; tbin[5] = 1'b0;
        for (int t = 0; t < 6; t++) begin
            model(ta[t], tb_[t], tbin[t], ed, eb, ei, elat);
            start_op(ta[t], tb_[t], tbin[t]);
            wait_done(lat, seen);
            n_total++;
            if (!seen || lat != elat)
                $display("FAIL dir%0d_latency: got seen=%b edges=%0d expected %0d", t, seen, lat, elat);
            else n_pass++;
            n_total++;
            if (diff !== ed || borrow_out !== eb || invalid !== ei)
                $display("FAIL dir%0d_result: got diff=%h brw=%b inv=%b expected diff=%h brw=%b inv=%b",
                         t, diff, borrow_out, invalid, ed, eb, ei);
            else n_pass++;
            n_total++;
            if (busy !== 1'b1)
                $display("FAIL dir%0d_busy_at_done: got %b expected 1", t, busy);
            else n_pass++;
            @(posedge clk);
            #1;
            n_total++;
            if (done !== 1'b0 || busy !== 1'b0 || diff !== ed || borrow_out !== eb || invalid !== ei)
                $display("FAIL dir%0d_after_done: got done=%b busy=%b diff=%h expected done=0 busy=0 diff=%h",
                         t, done, busy, diff, ed);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb, ed;
        logic         rbin, eb, ei, seen;
        int           elat, lat;
        for (int t = 0; t < 40; t++) begin
            ra = rand_bcd(); rb = rand_bcd(); rbin = 1'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                if ($urandom_range(0, 1) == 0) ra[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
                else                           rb[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
            end
            model(ra, rb, rbin, ed, eb, ei, elat);
            start_op(ra, rb, rbin);
            wait_done(lat, seen);
            n_total++;
            if (!seen || lat != elat || diff !== ed || borrow_out !== eb || invalid !== ei)
                $display("FAIL rand%0d a=%h b=%h bin=%b: got seen=%b lat=%0d diff=%h brw=%b inv=%b expected lat=%0d diff=%h brw=%b inv=%b",
                         t, ra, rb, rbin, seen, lat, diff, borrow_out, invalid, elat, ed, eb, ei);
            else n_pass++;
            @(posedge clk);
        end
    endtask

    task automatic test_busy_ignore();
        logic [W-1:0] ed, ed2;
        logic         eb, ei, eb2, ei2;
        int           elat, elat2, ndone, first_edge, edges;
        logic [W-1:0] got_d;
        logic         got_b;
        model(16'h0503, 16'h0278, 1'b0, ed, eb, ei, elat);
        model(16'h0001, 16'h0002, 1'b1, ed2, eb2, ei2, elat2);
        start_op(16'h0503, 16'h0278, 1'b0);
        @(posedge clk);
        @(negedge clk);
        a = 16'h0001; b = 16'h0002; bin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        edges = 2; ndone = 0; first_edge = 0; got_d = '0; got_b = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            edges++;
            #1;
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    first_edge = edges; got_d = diff; got_b = borrow_out;
                end
            end
        end
        n_total++;
        if (ndone != 1)
            $display("FAIL busy_ignore_pulses: got %0d done pulses expected 1", ndone);
        else n_pass++;
        n_total++;
        if (got_d !== ed || got_b !== eb || first_edge != elat)
            $display("FAIL busy_ignore_result: got diff=%h brw=%b edge=%0d expected diff=%h brw=%b edge=%0d",
                     got_d, got_b, first_edge, ed, eb, elat);
        else n_pass++;
        n_total++;
        if (diff !== ed)
            $display("FAIL busy_ignore_hold: got diff=%h expected %h", diff, ed);
        else n_pass++;
    endtask

    task automatic test_reset_midop();
        logic [W-1:0] ed;
        logic         eb, ei, seen;
        int           elat, lat, ndone;
        start_op(16'h4321, 16'h1234, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({busy, done, diff, borrow_out, invalid} !== '0)
            $display("FAIL midop_reset_outputs: got busy=%b done=%b diff=%h brw=%b inv=%b expected all 0",
                     busy, done, diff, borrow_out, invalid);
        else n_pass++;
        ndone = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        n_total++;
        if (ndone != 0 || busy !== 1'b0)
            $display("FAIL midop_no_done: got %0d done pulses busy=%b expected 0 0", ndone, busy);
        else n_pass++;
        model(16'h4321, 16'h1234, 1'b1, ed, eb, ei, elat);
        start_op(16'h4321, 16'h1234, 1'b1);
        wait_done(lat, seen);
        n_total++;
        if (!seen || lat != elat || diff !== ed || borrow_out !== eb)
            $display("FAIL midop_recover: got seen=%b lat=%0d diff=%h brw=%b expected lat=%0d diff=%h brw=%b",
                     seen, lat, diff, borrow_out, elat, ed, eb);
        else n_pass++;
        @(posedge clk);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ed;
        logic         eb, ei;
        int           elat, edges, d1, d2, nd;
        logic         ok;
        model(16'h0100, 16'h0099, 1'b0, ed, eb, ei, elat);
        @(negedge clk);
        a = 16'h0100; b = 16'h0099; bin = 1'b0; start = 1'b1;
        edges = -1; d1 = -1; d2 = -1; nd = 0; ok = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            edges++;
            #1;
            if (done) begin
                nd++;
                if (diff !== ed || borrow_out !== eb) ok = 1'b0;
                if (nd == 1) d1 = edges;
                if (nd == 2) begin
                    d2 = edges;
                    break;
                end
            end
        end
        @(negedge clk) start = 1'b0;
        n_total++;
        if (d1 != elat || d2 - d1 != int'(DIGITS) + 3)
            $display("FAIL held_start_timing: got first=%0d gap=%0d expected first=%0d gap=%0d",
                     d1, d2 - d1, elat, int'(DIGITS) + 3);
        else n_pass++;
        n_total++;
        if (!ok || nd != 2)
            $display("FAIL held_start_result: got pulses=%0d ok=%b diff=%h expected 2 pulses diff=%h", nd, ok, diff, ed);
        else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (busy !== 1'b0)
            $display("FAIL held_start_release: got busy=%b expected 0", busy);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_reset_midop();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
